// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: request/response bundle between the execute stage and the
// RV32M multiply/divide unit. The pipeline side is the master; the unit is the slave.
interface muldiv_unit_if #(
    parameter int N = 32
);
    logic         start;
    logic [2:0]   funct3;
    logic [N-1:0] A;
    logic [N-1:0] B;
    logic         kill;
    logic         busy;
    logic         done;
    logic [N-1:0] result;

    modport master (
        output start, funct3, A, B, kill,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, A, B, kill,
        output busy, done, result
    );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (one bit per cycle).
// Operands become magnitudes on accept; the sign is re-applied in DONE.
// Divide-by-zero and signed overflow bypass CALC and go straight to DONE.
// Optional feature macro: MULDIV_FAST_MUL_EN -- multiplies use a single-cycle
// combinational product and also go straight to DONE; divides are unchanged.
module muldiv_unit #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    muldiv_unit_if.slave bus
);
    localparam int CW = $clog2(N);

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q;
    logic [N-1:0]   a_mag_q, b_mag_q;
    logic           neg_q;
    logic [2*N-1:0] prod_q;
    logic [N-1:0]   rem_q, quo_q;
    logic [CW-1:0]  cnt_q;
    logic           spec_q;
    logic [N-1:0]   spec_val_q;
    logic [N-1:0]   res_q;

    // ---------------- accept-side decode ----------------
    logic           accept;
    logic           a_sgn_in, b_sgn_in, a_neg_in, b_neg_in;
    logic [N-1:0]   a_mag_in, b_mag_in;
    logic           div_zero_in, ovf_in, special_in, fast_mul_in, neg_in;
    logic [N-1:0]   spec_val_in;

    assign accept   = (state_q == IDLE) && bus.start && !bus.kill;
    assign a_sgn_in = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_MULHSU) ||
                      (bus.funct3 == OP_DIV)  || (bus.funct3 == OP_REM);
    assign b_sgn_in = (bus.funct3 == OP_MULH) || (bus.funct3 == OP_DIV) ||
                      (bus.funct3 == OP_REM);
    assign a_neg_in = a_sgn_in && bus.A[N-1];
    assign b_neg_in = b_sgn_in && bus.B[N-1];
    assign a_mag_in = a_neg_in ? (~bus.A + 1'b1) : bus.A;
    assign b_mag_in = b_neg_in ? (~bus.B + 1'b1) : bus.B;

    assign div_zero_in = bus.funct3[2] && (bus.B == '0);
    assign ovf_in      = ((bus.funct3 == OP_DIV) || (bus.funct3 == OP_REM)) &&
                         (bus.A == {1'b1, {(N-1){1'b0}}}) && (bus.B == '1);
    assign special_in  = div_zero_in || ovf_in;

    // funct3[1] separates remainder ops from quotient ops among the divides
    assign spec_val_in = div_zero_in ? (bus.funct3[1] ? bus.A : '1)
                                     : (bus.funct3[1] ? '0 : {1'b1, {(N-1){1'b0}}});

    // product sign from both operands; quotient likewise; remainder follows A
    assign neg_in = (bus.funct3[2] && bus.funct3[1]) ? a_neg_in : (a_neg_in ^ b_neg_in);

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul_in = ~bus.funct3[2];
`else
    assign fast_mul_in = 1'b0;
`endif

    // ---------------- iteration datapath ----------------
    logic [N:0]   msum;
    logic [N:0]   dsh;
    logic         dge;
    logic [N-1:0] ddif;

    assign msum = {1'b0, prod_q[2*N-1:N]} + {1'b0, (prod_q[0] ? a_mag_q : {N{1'b0}})};
    assign dsh  = {rem_q, quo_q[N-1]};
    assign dge  = dsh >= {1'b0, b_mag_q};
    assign ddif = dsh[N-1:0] - b_mag_q;

    // ---------------- final sign correction ----------------
    logic [2*N-1:0] prod_s;
    logic [N-1:0]   quo_s, rem_s, fin;

    // Result presented in DONE: special value, or magnitude with sign re-applied
    always_comb begin
        prod_s = neg_q ? (~prod_q + 1'b1) : prod_q;
        quo_s  = neg_q ? (~quo_q + 1'b1) : quo_q;
        rem_s  = neg_q ? (~rem_q + 1'b1) : rem_q;
        fin    = '0;
        if (spec_q)
            fin = spec_val_q;
        else if (!op_q[2])
            fin = (op_q == OP_MUL) ? prod_s[N-1:0] : prod_s[2*N-1:N];
        else
            fin = op_q[1] ? rem_s : quo_s;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    // Next-state: kill overrides everything and returns to IDLE
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (accept) state_d = (special_in || fast_mul_in) ? DONE : CALC;
            CALC: if (cnt_q == CW'(N-1)) state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (bus.kill)
            state_d = IDLE;
    end

    // Operand latch on accept, one shift-add / restoring step per CALC cycle,
    // and result commit in DONE (a killed DONE is discarded)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= '0;
            a_mag_q    <= '0;
            b_mag_q    <= '0;
            neg_q      <= 1'b0;
            prod_q     <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            cnt_q      <= '0;
            spec_q     <= 1'b0;
            spec_val_q <= '0;
            res_q      <= '0;
        end else begin
            if (accept) begin
                op_q       <= bus.funct3;
                a_mag_q    <= a_mag_in;
                b_mag_q    <= b_mag_in;
                neg_q      <= neg_in;
                spec_q     <= special_in;
                spec_val_q <= spec_val_in;
                cnt_q      <= '0;
                rem_q      <= '0;
                quo_q      <= a_mag_in;
`ifdef MULDIV_FAST_MUL_EN
                prod_q     <= {{N{1'b0}}, a_mag_in} * {{N{1'b0}}, b_mag_in};
`else
                // multiplier sits in the low half and shifts out LSB first
                prod_q     <= {{N{1'b0}}, b_mag_in};
`endif
            end else if (state_q == CALC && !bus.kill) begin
                cnt_q <= cnt_q + 1'b1;
                if (!op_q[2]) begin
                    prod_q <= {msum, prod_q[N-1:1]};
                end else begin
                    rem_q <= dge ? ddif : dsh[N-1:0];
                    quo_q <= {quo_q[N-2:0], dge};
                end
            end
            if (state_q == DONE && !bus.kill)
                res_q <= fin;
        end
    end

    assign bus.busy   = (state_q != IDLE);
    assign bus.done   = (state_q == DONE);
    assign bus.result = (state_q == DONE) ? fin : res_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + randomized bench for muldiv_unit against a
// cycle-level behavioural model built from plain 64-bit arithmetic.
module tb_muldiv_unit;
    localparam int N = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    muldiv_unit_if #(.N(N)) bus();
    muldiv_unit #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Architectural RV32M result
    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a,
                                               input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        int ia, ib;
        bit ovf;
        sa = $signed(a); sb = $signed(b);
        ua = {32'd0, a}; ub = {32'd0, b};
        ia = a; ib = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p = '0;
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(ia / ib);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(ia % ib);
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // Cycles from the accept edge to the done cycle
    function automatic int ref_latency(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
        if (!f[2]) begin
`ifdef MULDIV_FAST_MUL_EN
            return 1;
`else
            return N + 1;
`endif
        end
        if (b == 0) return 1;
        if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
        return N + 1;
    endfunction

    // Behavioural timeline: idle / counting down to done / done cycle
    bit          m_busy = 0, m_done = 0;
    int          m_left = 0;
    logic [31:0] m_res = '0, m_pend = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 0; m_done <= 0; m_left <= 0; m_res <= '0; m_pend <= '0;
        end else if (bus.kill) begin
            m_busy <= 0; m_done <= 0; m_left <= 0;
        end else if (m_done) begin
            m_res <= m_pend; m_busy <= 0; m_done <= 0;
        end else if (m_busy) begin
            m_left <= m_left - 1;
            if (m_left == 1) m_done <= 1;
        end else if (bus.start) begin
            m_pend <= ref_result(bus.funct3, bus.A, bus.B);
            m_left <= ref_latency(bus.funct3, bus.A, bus.B) - 1;
            m_busy <= 1;
            m_done <= (ref_latency(bus.funct3, bus.A, bus.B) == 1);
        end
    end

    // Every cycle: DUT outputs against the model
    always @(negedge clk) begin
        check("cyc_busy", 32'(bus.busy), 32'(m_busy));
        check("cyc_done", 32'(bus.done), 32'(m_done));
        check("cyc_result", bus.result, m_done ? m_pend : m_res);
    end

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'd1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            default: return $urandom;
        endcase
    endfunction

    // One operation; start pulses with junk operands at cycles poke_a/poke_b
    task automatic run_op(input string name, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input int poke_a, input int poke_b);
        int n = 0;
        bit seen = 0;
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct3 = f; bus.A = a; bus.B = b;
        @(posedge clk); #2;
        bus.start = 1'b0; bus.A = $urandom; bus.B = $urandom; bus.funct3 = 3'($urandom);
        while (n < 100 && !seen) begin
            @(negedge clk);
            n++;
            if (bus.done) seen = 1;
            else if (n == poke_a || n == poke_b) begin
                bus.start = 1'b1; bus.A = 32'd3; bus.B = 32'd1; bus.funct3 = 3'b101;
            end else bus.start = 1'b0;
        end
        bus.start = 1'b0;
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
        else begin
            check(name, bus.result, exp);
            check({name, "_lat"}, 32'(n), 32'(lat));
        end
    endtask

    // Start an op and kill it after k cycles
    task automatic run_kill(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                            input int k);
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct3 = f; bus.A = a; bus.B = b;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (k - 1) @(posedge clk);
        #2 bus.kill = 1'b1;
        @(posedge clk); #2;
        bus.kill = 1'b0;
    endtask

    int mul_lat;

    initial begin
        bus.start = 0; bus.kill = 0; bus.funct3 = '0; bus.A = '0; bus.B = '0;
`ifdef MULDIV_FAST_MUL_EN
        mul_lat = 1;
`else
        mul_lat = 33;
`endif
        // pin the reference model with hand-computed values
        check("ref_mul",    ref_result(3'd0, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
        check("ref_mulh",   ref_result(3'd1, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
        check("ref_mulhu",  ref_result(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
        check("ref_mulhsu", ref_result(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);
        check("ref_div",    ref_result(3'd4, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFD);
        check("ref_rem",    ref_result(3'd6, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'd0);

        run_op("mul",    3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, mul_lat, 0, 0);
        run_op("mulh",   3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, mul_lat, 0, 0);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, mul_lat, 0, 0);
        run_op("div",    3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, 0);
        run_op("rem",    3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 0);
        run_op("divu",   3'd5, 32'd100, 32'd7, 32'd14, 33, 0, 0);
        run_op("divu0",  3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, 0);
        run_op("rem0",   3'd6, 32'd5, 32'd0, 32'd5, 1, 0, 0);
        run_op("divovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, 0);
        run_op("removf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
        run_op("divu_b", 3'd5, 32'd100, 32'd7, 32'd14, 33, 0, 0);

        // kill during cycle 10 of a DIV: idle in cycle 11, result untouched
        run_kill(3'd4, 32'hFFFF_FFF9, 32'd2, 10);
        @(negedge clk);
        check("kill_busy", 32'(bus.busy), 32'd0);
        check("kill_result", bus.result, 32'd14);
        run_op("after_kill", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, 0);

        // start pulses while busy are ignored
        run_op("ignore_start", 3'd5, 32'd100, 32'd7, 32'd14, 33, 5, 20);

        // asynchronous reset in the middle of CALC
        @(posedge clk); #2;
        bus.start = 1'b1; bus.funct3 = 3'd7; bus.A = 32'd1000; bus.B = 32'd3;
        @(posedge clk); #2;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_done", 32'(bus.done), 32'd0);
        check("rst_result", bus.result, 32'd0);
        @(posedge clk); #2 rst_n = 1'b1;

        // randomized operations, some killed at random points
        for (int i = 0; i < 60; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom);
            a = rnd_operand();
            b = rnd_operand();
            if ($urandom_range(0, 4) == 0)
                run_kill(f, a, b, int'($urandom_range(1, 36)));
            else
                run_op("rand", f, a, b, ref_result(f, a, b), ref_latency(f, a, b), 0, 0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
